// File: rtl/md_hilo_sched.sv
// HI/LO multi-cycle scheduler: sequences the mult/div unit through a fixed
// busy window after an EX-stage issue and stalls decode while a HI/LO
// consumer or producer sits in ID during that window.
module md_hilo_sched #(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10,
   parameter int unsigned CW       = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       IntReq,
   input  logic       md_start_E,
   input  logic [1:0] md_op_E,
   input  logic       hilo_use_D,
   output logic       Start,
   output logic       Signed_E,
   output logic       Div_E,
   output logic       Busy,
   output logic       Done,
   output logic       Stall_MD
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Counter load values are latency-1 so that counter==0 marks the last busy cycle.
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC - 1);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          start_q, start_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          signed_q, signed_d;
   logic          div_q, div_d;

   logic          issue;
   logic [CW-1:0] load_val;

   assign issue    = (state_q == IDLE) && md_start_E && !IntReq;
   assign load_val = md_op_E[1] ? DIV_LD : MULT_LD;

   // Next-state decode; Done is decoded one cycle early so it is registered.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      start_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      signed_d = signed_q;
      div_d    = div_q;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d  = RUN;
               cnt_d    = load_val;
               start_d  = 1'b1;
               busy_d   = 1'b1;
               done_d   = (load_val == '0);
               div_d    = md_op_E[1];
               signed_d = ~md_op_E[0];
            end
         end
         RUN: begin
            // Issues arriving while running are ignored; only the countdown advances.
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d  = cnt_q - CW'(1);
               busy_d = 1'b1;
               done_d = (cnt_q == CW'(1));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously by Reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         signed_q <= 1'b0;
         div_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         signed_q <= signed_d;
         div_q    <= div_d;
      end
   end

   assign Start    = start_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Signed_E = signed_q;
   assign Div_E    = div_q;
   assign Stall_MD = hilo_use_D & (busy_q | (md_start_E & ~IntReq));

endmodule

// File: tb/tb_md_hilo_sched.sv
// Scoreboard bench for md_hilo_sched: directed per-cycle vectors push their
// hand-computed expected outputs; a monitor pops and compares mid-cycle.
module tb_md_hilo_sched;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       IntReq = 1'b0;
   logic       md_start_E = 1'b0;
   logic [1:0] md_op_E = 2'b00;
   logic       hilo_use_D = 1'b0;

   logic Start0, Signed0, Div0, Busy0, Done0, Stall0;
   logic Start1, Signed1, Div1, Busy1, Done1, Stall1;

   md_hilo_sched u_dut (
      .Clk(Clk), .Reset(Reset), .IntReq(IntReq), .md_start_E(md_start_E),
      .md_op_E(md_op_E), .hilo_use_D(hilo_use_D), .Start(Start0),
      .Signed_E(Signed0), .Div_E(Div0), .Busy(Busy0), .Done(Done0),
      .Stall_MD(Stall0)
   );

   // Short-latency instance for the single-cycle and back-to-back boundaries.
   md_hilo_sched #(.MULT_CYC(1), .DIV_CYC(2), .CW(2)) u_dut1 (
      .Clk(Clk), .Reset(Reset), .IntReq(IntReq), .md_start_E(md_start_E),
      .md_op_E(md_op_E), .hilo_use_D(hilo_use_D), .Start(Start1),
      .Signed_E(Signed1), .Div_E(Div1), .Busy(Busy1), .Done(Done1),
      .Stall_MD(Stall1)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int         id;
      logic       dsel;
      logic [5:0] exp;   // {Start, Busy, Done, Signed_E, Div_E, Stall_MD}
   } vec_t;

   vec_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   vid = 0;

   function automatic string fname(input int i);
      case (i)
         5: return "Start";
         4: return "Busy";
         3: return "Done";
         2: return "Signed_E";
         1: return "Div_E";
         default: return "Stall_MD";
      endcase
   endfunction

   // Drive one cycle of inputs just after the edge and queue its expectation.
   task automatic cyc(input logic rst, input logic st, input logic [1:0] op,
                      input logic irq, input logic use_d, input logic dsel,
                      input logic [5:0] exp);
      @(posedge Clk);
      #1;
      Reset      = rst;
      md_start_E = st;
      md_op_E    = op;
      IntReq     = irq;
      hilo_use_D = use_d;
      q.push_back('{vid, dsel, exp});
      vid++;
   endtask

   // Monitor: sample outputs at mid-cycle and compare against the queue head.
   initial begin
      vec_t       v;
      logic [5:0] act;
      forever begin
         @(negedge Clk);
         if (q.size() > 0) begin
            v = q.pop_front();
            act = v.dsel ? {Start1, Busy1, Done1, Signed1, Div1, Stall1}
                         : {Start0, Busy0, Done0, Signed0, Div0, Stall0};
            for (int i = 0; i < 6; i++) begin
               checks++;
               if (act[i] !== v.exp[i]) begin
                  errors++;
                  $display("FAIL vec%0d dut%0d %s: got %b expected %b",
                           v.id, v.dsel, fname(i), act[i], v.exp[i]);
               end
            end
         end
      end
   end

   initial begin
      // Reset held for 3 cycles, then idle.
      repeat (3) cyc(0, 0, 2'b00, 0, 0, 0, 6'b000000);
      repeat (5) cyc(1, 0, 2'b00, 0, 0, 0, 6'b000000);
      // mult issued: Start one cycle, Busy 5 cycles, Done on the last.
      cyc(1, 1, 2'b00, 0, 0, 0, 6'b000000);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b110100);
      repeat (3) cyc(1, 0, 2'b00, 0, 0, 0, 6'b010100);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b011100);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b000100);
      // div with a HI/LO user held in ID: stall through the Done cycle.
      cyc(1, 1, 2'b10, 0, 1, 0, 6'b000101);
      cyc(1, 0, 2'b00, 0, 1, 0, 6'b110111);
      repeat (8) cyc(1, 0, 2'b00, 0, 1, 0, 6'b010111);
      cyc(1, 0, 2'b00, 0, 1, 0, 6'b011111);
      cyc(1, 0, 2'b00, 0, 1, 0, 6'b000110);
      // Issue cancelled by IntReq: no stall, no Start, no Busy.
      cyc(1, 1, 2'b00, 1, 1, 0, 6'b000110);
      cyc(1, 0, 2'b00, 0, 1, 0, 6'b000110);
      // divu aborted by a reset pulse mid-run: no Done afterwards.
      cyc(1, 1, 2'b11, 0, 0, 0, 6'b000110);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b110010);
      repeat (2) cyc(1, 0, 2'b00, 0, 0, 0, 6'b010010);
      cyc(0, 0, 2'b00, 0, 0, 0, 6'b000000);
      repeat (11) cyc(1, 0, 2'b00, 0, 0, 0, 6'b000000);
      // multu then div issued the cycle after Busy drops.
      cyc(1, 1, 2'b01, 0, 0, 0, 6'b000000);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b110000);
      repeat (3) cyc(1, 0, 2'b00, 0, 0, 0, 6'b010000);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b011000);
      cyc(1, 1, 2'b10, 0, 0, 0, 6'b000000);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b110110);
      repeat (8) cyc(1, 0, 2'b00, 0, 0, 0, 6'b010110);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b011110);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b000110);
      // Stray md_start_E during a running mult is ignored.
      cyc(1, 1, 2'b00, 0, 0, 0, 6'b000110);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b110100);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b010100);
      cyc(1, 1, 2'b10, 0, 0, 0, 6'b010100);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b010100);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b011100);
      cyc(1, 0, 2'b00, 0, 0, 0, 6'b000100);
      // Latency-1 mult then latency-2 divu back-to-back on the short instance.
      cyc(0, 0, 2'b00, 0, 0, 1, 6'b000000);
      cyc(1, 1, 2'b00, 0, 1, 1, 6'b000001);
      cyc(1, 0, 2'b00, 0, 1, 1, 6'b111101);
      cyc(1, 1, 2'b11, 0, 1, 1, 6'b000101);
      cyc(1, 0, 2'b00, 0, 1, 1, 6'b110011);
      cyc(1, 0, 2'b00, 0, 1, 1, 6'b011011);
      cyc(1, 0, 2'b00, 0, 1, 1, 6'b000010);

      // Every queued expectation must have been consumed by the monitor.
      @(posedge Clk);
      @(negedge Clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_hilo_sched.md
Name: md_hilo_sched

Overview:
- Multi-cycle scheduler for the HI/LO resource that the decode stage forwards from (HI_MEM/LO_MEM/HI_WB/LO_WB paths).
- Accepts a mult/div issue from EX and sequences the multiply/divide unit through a fixed-latency busy window.
- Raises a decode-stage stall while any HI/LO consumer or producer sits in ID during that window.
- Emits the one-cycle HI/LO write strobe on completion. Sits beside the hazard unit; its stall is ORed into the pipeline Enable.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu (≥1).
- DIV_CYC, 10, busy cycles for div/divu (≥1).
- CW, 4, counter width; must satisfy 2^CW > max(MULT_CYC, DIV_CYC).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- IntReq  input  1  exception/interrupt flush; cancels an issue presented in the same cycle.
- md_start_E  input  1  a mult/multu/div/divu is in EX this cycle.
- md_op_E  input  2  00 mult, 01 multu, 10 div, 11 divu.
- hilo_use_D  input  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu.
- Start  output  1  one-cycle launch pulse to the MDU (registered).
- Signed_E  output  1  latched signedness of the running op (1 = mult/div).
- Div_E  output  1  latched op class (1 = divide).
- Busy  output  1  MDU occupied (registered).
- Done  output  1  one-cycle HI/LO write enable, asserted on the last busy cycle.
- Stall_MD  output  1  freeze IF/ID, bubble EX (combinational).

Behaviour:
- Reset (Reset=0, any time, async): state IDLE, counter 0; Start, Busy, Done, Signed_E, Div_E all 0. Stall_MD is combinational and follows its equation.
- States: IDLE, RUN.
- Issue accepted in cycle t when state=IDLE, md_start_E=1 and IntReq=0. "Issue" below means this condition.
- On accepted issue at edge end of t:
  - state←RUN.
  - counter←(md_op_E[1] ? DIV_CYC : MULT_CYC)−1.
  - Div_E←md_op_E[1]; Signed_E←~md_op_E[0].
  - Start←1; Busy←1.
- Start is high only in cycle t+1. It is cleared on the next edge unless a new issue occurs.
- RUN: counter decrements by 1 each edge. Busy=1 for cycles t+1 … t+N, where N = the op latency.
- Done is registered: Done=1 exactly in cycle t+N, i.e. when state=RUN and counter=0 at that cycle's start. Implement as next-state decode, not a combinational output.
- In cycle t+N (counter=0), the edge returns state to IDLE; Busy and Done go 0 in t+N+1.
- Signed_E and Div_E hold until the next accepted issue.
- Latency 1 (N=1): Start, Busy and Done all high in t+1 only.
- Stall_MD = hilo_use_D & (Busy | (md_start_E & ~IntReq)).
  - ID is therefore held through cycle t+N.
  - mfhi/mflo in ID proceeds at t+N+1 and reads the written HI/LO through the WB/MEM forwarding paths.
- Back-to-back: an issue in cycle t+N+1 is accepted normally. There is no dead cycle beyond Busy deassertion.
- md_start_E while state=RUN: ignored; state, counter and latched fields unchanged. This is an upstream protocol violation, because the stall rule prevents it.
- IntReq=1 with md_start_E=1 in IDLE: issue cancelled, no Start, Stall_MD=0.
- IntReq during RUN: no effect. A committed op completes and Done still fires.
- Reset during RUN: immediate abort to IDLE. No Done pulse; Busy drops asynchronously.
- Counter never wraps: it only decrements from a loaded value to 0, then state leaves RUN.

Test Plan:
- Reset low 3 cycles, release → Start=Busy=Done=0, Stall_MD=0. Then md_start_E=1, md_op_E=00 at cycle 5 → Start=1 at 6 only; Busy=1 cycles 6–10; Done=1 at 10; Busy=0 at 11; Signed_E=1, Div_E=0.
- div (md_op_E=10) at cycle 2, mflo in ID (hilo_use_D=1) from cycle 2 → Stall_MD=1 cycles 2–12, 0 at 13; Done only at 12.
- md_start_E=1 with IntReq=1, hilo_use_D=1 → Start never asserts, Busy stays 0, Stall_MD=0 that cycle.
- divu at cycle 0, Reset pulsed low at cycle 4 → Busy/state cleared asynchronously mid-cycle; no Done in cycles 0–15.
- multu at cycle 0 (Done at 5), new div issued at cycle 6 → second Start at 7; Signed_E=0 for cycles 1–6, then 1; Div_E=1; Done at 16.
- md_start_E pulsed at cycle 3 during an active mult → counter unaffected; Done still at cycle 5; no second Start.
